// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial borrow-ripple subtractor, D = A - B - BI, LSB first
module serial_subtractor #(
    parameter int SIZE = 4,
    parameter int CW   = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [SIZE-1:0] A,
    input  logic [SIZE-1:0] B,
    input  logic            BI,
    output logic [SIZE-1:0] D,
    output logic            BO,
    output logic            Z,
    output logic            V,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(SIZE - 1);

    state_t          state_q, state_d;
    logic [SIZE-1:0] ra_q, ra_d;
    logic [SIZE-1:0] rb_q, rb_d;
    logic            br_q, br_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0] res_q, res_d;
    logic [SIZE-1:0] d_q, d_d;
    logic            bo_q, bo_d;
    logic            z_q, z_d;
    logic            v_q, v_d;

    logic            diff_bit;
    logic            borrow_nxt;
    logic [SIZE-1:0] res_shifted;

    // Single full-subtractor cell working on the current LSB of the operand shifters
    always_comb begin
        diff_bit    = ra_q[0] ^ rb_q[0] ^ br_q;
        borrow_nxt  = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & br_q);
        res_shifted = {diff_bit, res_q[SIZE-1:1]};
    end

    // Next-state and datapath update; published results only move on the final shift edge
    always_comb begin
        state_d  = state_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        br_d     = br_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        d_d      = d_q;
        bo_d     = bo_q;
        z_d      = z_q;
        v_d      = v_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    ra_d     = A;
                    rb_d     = B;
                    br_d     = BI;
                    sign_a_d = A[SIZE-1];
                    sign_b_d = B[SIZE-1];
                    cnt_d    = '0;
                    res_d    = '0;
                    state_d  = S_SHIFT;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_SHIFT: begin
                res_d = res_shifted;
                ra_d  = ra_q >> 1;
                rb_d  = rb_q >> 1;
                br_d  = borrow_nxt;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    d_d     = res_shifted;
                    bo_d    = borrow_nxt;
                    z_d     = (res_shifted == '0);
                    v_d     = (sign_a_q ^ sign_b_q) & (res_shifted[SIZE-1] ^ sign_a_q);
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation and clears every result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ra_q     <= '0;
            rb_q     <= '0;
            br_q     <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
            d_q      <= '0;
            bo_q     <= 1'b0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            br_q     <= br_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            d_q      <= d_d;
            bo_q     <= bo_d;
            z_q      <= z_d;
            v_q      <= v_d;
        end
    end

    assign D    = d_q;
    assign BO   = bo_q;
    assign Z    = z_q;
    assign V    = v_q;
    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor
module tb_serial_subtractor;

    localparam int SIZE = 4;
    localparam int CW   = 3;

    typedef struct {
        logic [SIZE-1:0] d;
        logic            bo;
        logic            z;
        logic            v;
        int              cyc;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [SIZE-1:0] A;
    logic [SIZE-1:0] B;
    logic            BI;
    logic [SIZE-1:0] D;
    logic            BO;
    logic            Z;
    logic            V;
    logic            busy;
    logic            done;

    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    exp_t sb_q[$];

    serial_subtractor #(.SIZE(SIZE), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .BI    (BI),
        .D     (D),
        .BO    (BO),
        .Z     (Z),
        .V     (V),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("D",          int'(D),  int'(e.d));
                chk("BO",         int'(BO), int'(e.bo));
                chk("Z",          int'(Z),  int'(e.z));
                chk("V",          int'(V),  int'(e.v));
                chk("done_cycle", cyc,      e.cyc);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_D"},    int'(D),    0);
        chk({tag, "_BO"},   int'(BO),   0);
        chk({tag, "_Z"},    int'(Z),    0);
        chk({tag, "_V"},    int'(V),    0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    // Drive start at the current negedge and register the expected outcome
    task automatic issue(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic bi,
                         input logic [SIZE-1:0] ed, input logic ebo, input logic ez,
                         input logic ev, input bit expect_done);
        exp_t e;
        A     = a;
        B     = b;
        BI    = bi;
        start = 1'b1;
        if (expect_done) begin
            e.d   = ed;
            e.bo  = ebo;
            e.z   = ez;
            e.v   = ev;
            e.cyc = cyc + 1 + SIZE;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 3 * SIZE + 4; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic do_op(input string tag,
                         input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic bi,
                         input logic [SIZE-1:0] ed, input logic ebo, input logic ez,
                         input logic ev);
        @(negedge clk);
        issue(a, b, bi, ed, ebo, ez, ev, 1'b1);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, int'(busy), 1);
        wait_done(tag);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, int'(done), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        BI    = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        do_op("sub_7_3",    4'd7, 4'd3,   1'b0, 4'd4,   1'b0, 1'b0, 1'b0);
        do_op("sub_3_7",    4'd3, 4'd7,   1'b0, 4'hC,   1'b1, 1'b0, 1'b0);
        do_op("sub_5_5",    4'd5, 4'd5,   1'b0, 4'd0,   1'b0, 1'b1, 1'b0);
        do_op("sub_5_5_bi", 4'd5, 4'd5,   1'b1, 4'hF,   1'b1, 1'b0, 1'b0);
        do_op("ovf_8_1",    4'd8, 4'd1,   1'b0, 4'd7,   1'b0, 1'b0, 1'b1);
        do_op("ovf_7_f",    4'd7, 4'hF,   1'b0, 4'd8,   1'b1, 1'b0, 1'b1);
        do_op("sub_0_0_bi", 4'd0, 4'd0,   1'b1, 4'hF,   1'b1, 1'b0, 1'b0);

        // Start while busy is ignored: exactly one done with the original result
        @(negedge clk);
        issue(4'd7, 4'd3, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        issue(4'd0, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("busy_ignore_D_held", int'(D), 8'hF);
        wait_done("busy_ignore");
        repeat (SIZE + 3) @(negedge clk);

        // Back-to-back: restart in the DONE cycle
        @(negedge clk);
        issue(4'd7, 4'd3, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_first");
        issue(4'd9, 4'd2, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", int'(busy), 1);
        chk("b2b_D_held", int'(D), 4);
        wait_done("b2b_second");
        @(negedge clk);

        // Reset in the middle of an operation: no done, outputs cleared
        @(negedge clk);
        issue(4'd6, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("midop_reset");
        rst_n = 1'b1;
        repeat (SIZE + 3) @(negedge clk);
        chk("midop_no_done_D", int'(D), 0);

        do_op("after_reset", 4'd2, 4'd1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);

        repeat (SIZE + 2) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
